// File: rtl/segment_addr_gen.sv
// segment_addr_gen: expands one segment instruction into a stream of waveform beat addresses.
// Latency: first wave_addr valid one cycle after an accepted strobe; beats and passes run back to back when gap is 0.
// Backpressure: wave_addr, wave_addr_valid and wave_last hold while wave_addr_ready is low; a beat moves on valid & ready.
//
// Ports:
//   clk, rst                 sole clock (rising edge) and synchronous active-high reset
//   segment_instruc[_valid]  128-bit instruction and its one-cycle qualifying strobe
//   stop                     level request to abort at the next beat boundary
//   wave_addr[_valid/_ready] beat address stream towards waveform memory, wave_last marks the final beat
//   generate_done            one-cycle pulse when a segment finishes or is aborted
//   busy, instr_err          not-idle indication and sticky bad-instruction flag
module segment_addr_gen #(
  parameter int unsigned ADDR_STEP = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] segment_instruc,
  input  logic         segment_instruc_valid,
  input  logic         stop,
  output logic [31:0]  wave_addr,
  output logic         wave_addr_valid,
  input  logic         wave_addr_ready,
  output logic         wave_last,
  output logic         generate_done,
  output logic         busy,
  output logic         instr_err
);

  localparam logic [2:0]  OP_SEGMENT = 3'b101;
  localparam logic [31:0] STEP       = 32'(ADDR_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;

  // Instruction field decode
  logic [2:0]  in_op;
  logic [31:0] in_base;
  logic [15:0] in_len;
  logic [15:0] in_rep;
  logic [15:0] in_gap;
  logic [15:0] in_passes_m1;
  logic        unused_instr_bits;

  assign in_op   = segment_instruc[127:125];
  assign in_base = segment_instruc[95:64];
  assign in_len  = segment_instruc[63:48];
  assign in_rep  = segment_instruc[47:32];
  assign in_gap  = segment_instruc[31:16];
  assign unused_instr_bits = ^{segment_instruc[124:96], segment_instruc[15:0]};

  // Repeat counts 0 and 1 both mean one pass, so the pass limit is kept as passes-1.
  assign in_passes_m1 = (in_rep == 16'd0) ? 16'd0 : in_rep - 16'd1;

  // Latched segment context
  logic [31:0] base_q;
  logic [15:0] len_q;
  logic [15:0] gap_q;
  logic [15:0] passes_m1_q;
  logic [15:0] pass_cnt;
  logic [15:0] beat_cnt;
  logic [15:0] gap_cnt;

  logic fire;
  logic beat_end;
  logic pass_end;
  logic next_pass_end;

  assign fire          = wave_addr_valid & wave_addr_ready;
  assign beat_end      = (beat_cnt == len_q - 16'd1);
  assign pass_end      = (pass_cnt == passes_m1_q);
  assign next_pass_end = ((pass_cnt + 16'd1) == passes_m1_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      wave_addr       <= 32'd0;
      wave_addr_valid <= 1'b0;
      wave_last       <= 1'b0;
      generate_done   <= 1'b0;
      busy            <= 1'b0;
      instr_err       <= 1'b0;
      base_q          <= 32'd0;
      len_q           <= 16'd0;
      gap_q           <= 16'd0;
      passes_m1_q     <= 16'd0;
      pass_cnt        <= 16'd0;
      beat_cnt        <= 16'd0;
      gap_cnt         <= 16'd0;
    end else begin
      generate_done <= 1'b0;

      // Any strobe that cannot start a segment is dropped and flagged; running work is untouched.
      if (segment_instruc_valid && ((state != S_IDLE) || (in_op != OP_SEGMENT))) begin
        instr_err <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (segment_instruc_valid && (in_op == OP_SEGMENT)) begin
            base_q      <= in_base;
            len_q       <= in_len;
            gap_q       <= in_gap;
            passes_m1_q <= in_passes_m1;
            pass_cnt    <= 16'd0;
            beat_cnt    <= 16'd0;
            busy        <= 1'b1;
            if (in_len == 16'd0) begin
              // Nothing to issue: report completion straight away.
              state <= S_DONE;
            end else begin
              state           <= S_ISSUE;
              wave_addr       <= in_base;
              wave_addr_valid <= 1'b1;
              wave_last       <= (in_len == 16'd1) && (in_passes_m1 == 16'd0);
            end
          end
        end

        S_ISSUE: begin
          // stop is only honoured on a transferring cycle so an offered beat is never withdrawn.
          if (fire) begin
            if ((beat_end && pass_end) || stop) begin
              state           <= S_DONE;
              wave_addr_valid <= 1'b0;
              wave_last       <= 1'b0;
            end else if (beat_end) begin
              pass_cnt <= pass_cnt + 16'd1;
              beat_cnt <= 16'd0;
              if (gap_q != 16'd0) begin
                state           <= S_GAP;
                gap_cnt         <= gap_q - 16'd1;
                wave_addr_valid <= 1'b0;
                wave_last       <= 1'b0;
              end else begin
                // Next pass restarts at base without a bubble.
                wave_addr <= base_q;
                wave_last <= (len_q == 16'd1) && next_pass_end;
              end
            end else begin
              beat_cnt  <= beat_cnt + 16'd1;
              wave_addr <= wave_addr + STEP;  // 32-bit wrap is intentional
              wave_last <= ((beat_cnt + 16'd1) == (len_q - 16'd1)) && pass_end;
            end
          end
        end

        S_GAP: begin
          if (stop) begin
            state <= S_DONE;
          end else if (gap_cnt == 16'd0) begin
            // pass_cnt already points at the pass about to start.
            state           <= S_ISSUE;
            wave_addr       <= base_q;
            wave_addr_valid <= 1'b1;
            wave_last       <= (len_q == 16'd1) && pass_end;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end

        S_DONE: begin
          // The done pulse appears the cycle after DONE, when the block is already idle again.
          generate_done <= 1'b1;
          busy          <= 1'b0;
          state         <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
